// File: rtl/fetch_pc.sv
// Instruction-fetch front end: owns the fetch PC, issues one word request at a
// time to instruction memory and fills the IF/ID register. Redirects squash younger work.
module fetch_pc #(
  parameter logic [29:0] RESET_PC = 30'h00000C00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [29:0] JPC,
  input  logic        stall,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [29:0] if_pcp1
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} st_t;

  st_t         st;
  logic [29:0] fa;
  logic        pend;
  logic [29:0] pend_tgt;
  logic [29:0] iss_pcp1;
  logic        accept;
  logic        capture;
  logic [29:0] nxt;

  assign imem_addr = redirect ? JPC : (pend ? pend_tgt : fa);
  // Only issue when the IF/ID slot will be free by the time data returns.
  assign imem_req  = !reset && (st == IDLE) && (!if_valid || !stall || redirect);
  assign accept    = imem_req && imem_ready;
  assign capture   = (st == WAIT) && imem_rvalid && !redirect;
  assign nxt       = imem_addr + 30'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= IDLE;
      fa       <= RESET_PC;
      pend     <= 1'b0;
      pend_tgt <= '0;
      iss_pcp1 <= '0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pcp1  <= '0;
    end else begin
      // A redirect accepted in the same cycle already went out as JPC.
      if (accept) begin
        fa       <= nxt;
        iss_pcp1 <= nxt;
        pend     <= 1'b0;
      end else if (redirect) begin
        pend     <= 1'b1;
        pend_tgt <= JPC;
      end

      case (st)
        IDLE: if (accept) st <= WAIT;
        WAIT: begin
          if (imem_rvalid)   st <= IDLE;
          else if (redirect) st <= DROP;
        end
        DROP: if (imem_rvalid) st <= IDLE;
        default: st <= IDLE;
      endcase

      if (redirect) begin
        if_valid <= 1'b0;
      end else if (capture) begin
        if_valid <= 1'b1;
        if_instr <= imem_rdata;
        if_pcp1  <= iss_pcp1;
      end else if (if_valid && !stall) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc.sv
// Bench for fetch_pc: directed scenarios plus a randomized run against a
// transaction-level model of fetch ordering, squashing and the IF/ID slot.
module tb_fetch_pc;

  localparam logic [29:0] RPC = 30'h00000C00;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [29:0] JPC;
  logic        stall;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [29:0] if_pcp1;

  int total = 0;
  int bad   = 0;

  fetch_pc #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .JPC(JPC), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pcp1(if_pcp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [29:0] a);
    return {a[15:0], ~a[15:0]} ^ {2'b00, a};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; stall = 1'b0; JPC = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b0; stall = 1'b0; JPC = '0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    cyc(); cyc();
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    total++; if (if_instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 0", if_instr); end
    total++; if (if_pcp1 !== 30'h0) begin bad++; $display("FAIL rst_pcp1: got %h want 0", if_pcp1); end
    reset = 1'b0; imem_ready = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_first_req: got %b want 1", imem_req); end
    total++; if (imem_addr !== RPC) begin bad++; $display("FAIL rst_first_addr: got %h want %h", imem_addr, RPC); end
  endtask

  task automatic test_sequential();
    logic [29:0] a;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a = RPC + 30'(i);
      total++; if (imem_req !== 1'b1 || imem_addr !== a) begin
        bad++; $display("FAIL seq_issue%0d: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, a);
      end
      imem_ready = 1'b1;
      cyc();
      imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = memw(a);
      #1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL seq_busy%0d: got req=%b want 0", i, imem_req); end
      cyc();
      imem_rvalid = 1'b0;
      #1;
      total++; if (if_valid !== 1'b1 || if_pcp1 !== a + 30'd1 || if_instr !== memw(a)) begin
        bad++; $display("FAIL seq_capture%0d: got v=%b pcp1=%h instr=%h want v=1 pcp1=%h instr=%h",
                        i, if_valid, if_pcp1, if_instr, a + 30'd1, memw(a));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = memw(RPC);
    cyc();
    imem_rvalid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_instr !== memw(RPC) || if_pcp1 !== RPC + 30'd1) begin
        bad++; $display("FAIL stall_hold%0d: got req=%b v=%b instr=%h pcp1=%h", i, imem_req, if_valid, if_instr, if_pcp1);
      end
      cyc();
    end
    stall = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== RPC + 30'd1) begin
      bad++; $display("FAIL stall_release: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RPC + 30'd1);
    end
    cyc();
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL stall_consume: got v=%b want 0", if_valid); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0; redirect = 1'b1; JPC = 30'h1060;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rdw_req: got %b want 0", imem_req); end
    cyc();
    redirect = 1'b0;
    cyc();
    imem_rvalid = 1'b1; imem_rdata = memw(RPC);
    cyc();
    imem_rvalid = 1'b0;
    #1;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rdw_discard: got v=%b want 0", if_valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 30'h1060) begin
      bad++; $display("FAIL rdw_target: got req=%b addr=%h want req=1 addr=1060", imem_req, imem_addr);
    end
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = memw(30'h1060);
    cyc();
    imem_rvalid = 1'b0;
    #1;
    total++; if (if_valid !== 1'b1 || if_pcp1 !== 30'h1061 || if_instr !== memw(30'h1060)) begin
      bad++; $display("FAIL rdw_capture: got v=%b pcp1=%h instr=%h want v=1 pcp1=1061", if_valid, if_pcp1, if_instr);
    end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0; redirect = 1'b1; JPC = 30'h0800; imem_rvalid = 1'b1; imem_rdata = memw(RPC);
    cyc();
    redirect = 1'b0; imem_rvalid = 1'b0;
    #1;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rdr_discard: got v=%b want 0", if_valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 30'h0800) begin
      bad++; $display("FAIL rdr_target: got req=%b addr=%h want req=1 addr=0800", imem_req, imem_addr);
    end
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = memw(30'h0800);
    cyc();
    imem_rvalid = 1'b0;
    #1;
    total++; if (if_valid !== 1'b1 || if_pcp1 !== 30'h0801 || if_instr !== memw(30'h0800)) begin
      bad++; $display("FAIL rdr_capture: got v=%b pcp1=%h instr=%h want v=1 pcp1=0801", if_valid, if_pcp1, if_instr);
    end
  endtask

  task automatic test_pending_redirect();
    do_reset();
    redirect = 1'b1; JPC = 30'h2000;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 30'h2000) begin
      bad++; $display("FAIL pend_first: got req=%b addr=%h want req=1 addr=2000", imem_req, imem_addr);
    end
    cyc();
    JPC = 30'h2400;
    cyc();
    redirect = 1'b0; JPC = 30'h0;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 30'h2400) begin
      bad++; $display("FAIL pend_latest: got req=%b addr=%h want req=1 addr=2400", imem_req, imem_addr);
    end
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = memw(30'h2400);
    cyc();
    imem_rvalid = 1'b0;
    #1;
    total++; if (if_valid !== 1'b1 || if_pcp1 !== 30'h2401) begin
      bad++; $display("FAIL pend_capture: got v=%b pcp1=%h want v=1 pcp1=2401", if_valid, if_pcp1);
    end
    total++; if (imem_req !== 1'b1 || imem_addr !== 30'h2401) begin
      bad++; $display("FAIL pend_seq: got req=%b addr=%h want req=1 addr=2401", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect = 1'b1; JPC = 30'h3FFFFFFF; imem_ready = 1'b1;
    #1;
    total++; if (imem_addr !== 30'h3FFFFFFF) begin bad++; $display("FAIL wrap_addr: got %h want 3fffffff", imem_addr); end
    cyc();
    redirect = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = memw(30'h3FFFFFFF);
    cyc();
    imem_rvalid = 1'b0;
    #1;
    total++; if (if_valid !== 1'b1 || if_pcp1 !== 30'h0 || if_instr !== memw(30'h3FFFFFFF)) begin
      bad++; $display("FAIL wrap_capture: got v=%b pcp1=%h instr=%h want v=1 pcp1=0", if_valid, if_pcp1, if_instr);
    end
    total++; if (imem_req !== 1'b1 || imem_addr !== 30'h0) begin
      bad++; $display("FAIL wrap_seq: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = memw(RPC);
    cyc();
    imem_rvalid = 1'b0; imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0; reset = 1'b1;
    cyc();
    #1;
    total++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_instr !== 32'h0 || if_pcp1 !== 30'h0) begin
      bad++; $display("FAIL mid_reset: got req=%b v=%b instr=%h pcp1=%h want all 0", imem_req, if_valid, if_instr, if_pcp1);
    end
    reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin
      bad++; $display("FAIL mid_restart: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RPC);
    end
    cyc();
    imem_rvalid = 1'b0;
    #1;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL mid_stray: got v=%b want 0", if_valid); end
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = memw(RPC);
    cyc();
    imem_rvalid = 1'b0;
    #1;
    total++; if (if_valid !== 1'b1 || if_pcp1 !== RPC + 30'd1 || if_instr !== memw(RPC)) begin
      bad++; $display("FAIL mid_capture: got v=%b pcp1=%h instr=%h", if_valid, if_pcp1, if_instr);
    end
  endtask

  // Model: next fetch target, one outstanding memory transaction with its own
  // latency, a squash mark for it, and the contents of the IF/ID slot.
  task automatic test_random();
    logic        busy, squash, ev, nv, er, acc;
    logic [29:0] enext, oaddr, epcp1, aa;
    logic [31:0] einstr;
    int          cnt;
    do_reset();
    busy = 0; squash = 0; ev = 0; enext = RPC; oaddr = '0; epcp1 = '0; einstr = '0; cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      stall      = ($urandom % 3) == 0;
      redirect   = ($urandom % 10) == 0;
      JPC        = (($urandom % 4) == 0) ? 30'h3FFFFFFF - 30'($urandom % 3) : 30'($urandom);
      imem_ready = ($urandom % 3) != 0;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (busy) begin
        if (cnt == 1) begin imem_rvalid = 1'b1; imem_rdata = memw(oaddr); end
        else cnt--;
      end
      #1;
      er = !busy && (!ev || !stall || redirect);
      aa = redirect ? JPC : enext;
      total++; if (imem_req !== er) begin bad++; $display("FAIL rnd_req c=%0d: got %b want %b", c, imem_req, er); end
      if (er) begin
        total++; if (imem_addr !== aa) begin bad++; $display("FAIL rnd_addr c=%0d: got %h want %h", c, imem_addr, aa); end
      end
      acc = er && imem_ready;
      nv = ev;
      if (redirect) nv = 0;
      else if (imem_rvalid && !squash) begin nv = 1; epcp1 = oaddr + 30'd1; einstr = memw(oaddr); end
      else if (ev && !stall) nv = 0;
      if (imem_rvalid) busy = 0;
      if (redirect) begin enext = JPC; if (busy) squash = 1; end
      if (acc) begin busy = 1; oaddr = aa; enext = aa + 30'd1; squash = 0; cnt = $urandom_range(1, 3); end
      ev = nv;
      cyc();
      total++; if (if_valid !== ev) begin bad++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, if_valid, ev); end
      if (ev) begin
        total++; if (if_pcp1 !== epcp1 || if_instr !== einstr) begin
          bad++; $display("FAIL rnd_data c=%0d: got pcp1=%h instr=%h want pcp1=%h instr=%h", c, if_pcp1, if_instr, epcp1, einstr);
        end
      end
    end
    redirect = 1'b0; stall = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_pending_redirect();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc.md
# fetch_pc

Instruction-fetch front end for the pipelined MIPS core: owns the fetch program counter, issues word requests to instruction memory, and fills the IF/ID instruction register. It sits at the IF stage and consumes the redirect target that the ID stage computes for branches, jumps, `jr`/`jalr`, `eret` and exception entry. Redirect squashes all younger fetch work (no delay slot). Addresses are word addresses [31:2] throughout.

## Interface

- `RESET_PC`, default 30'h00000C00 (byte 0x00003000): fetch address after reset.
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `redirect`  in  1  one-cycle pulse from ID: the next fetch goes to `JPC` and all younger fetch work is discarded.
- `JPC`  in  30  redirect target, valid when `redirect`=1.
- `stall`  in  1  hazard unit: ID does not consume `if_instr` this cycle.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  30  request word address.
- `imem_ready`  in  1  memory accepts the request; accept = `imem_req & imem_ready`.
- `imem_rvalid`  in  1  read data valid, at least 1 cycle after accept, in order.
- `imem_rdata`  in  32  instruction word.
- `if_valid`  out  1  IF/ID register holds a valid instruction.
- `if_instr`  out  32  fetched instruction.
- `if_pcp1`  out  30  fetch address + 1 of `if_instr` (ID's PC base).

## Operation

- State: `st` ∈ {IDLE, WAIT, DROP}; `fa` (next sequential address); `pend`/`pend_tgt` (latched redirect); `iss_pcp1` (address+1 of the outstanding request); output register `if_valid`/`if_instr`/`if_pcp1`.
- Address select (combinational): `imem_addr = redirect ? JPC : pend ? pend_tgt : fa`.
- `imem_req = !reset & st==IDLE & (!if_valid | !stall | redirect)`.
- At most one request outstanding.
- Accept: `fa <= imem_addr+1`, `iss_pcp1 <= imem_addr+1`, `pend <= 0`, `st <= WAIT`.
- Redirect without accept in the same cycle: `pend <= 1`, `pend_tgt <= JPC`. A later redirect overwrites `pend_tgt`.
- Redirect with accept in the same cycle: the accepted address is already `JPC`, so `pend` stays 0.
- FSM transitions:
  - IDLE → WAIT on accept.
  - WAIT + `imem_rvalid` + !`redirect` → IDLE. Capture: `if_valid <= 1`, `if_instr <= imem_rdata`, `if_pcp1 <= iss_pcp1`.
  - WAIT + `redirect` without `imem_rvalid` → DROP.
  - WAIT + `redirect` + `imem_rvalid` → IDLE; data discarded.
  - DROP + `imem_rvalid` → IDLE; data discarded.
  - `imem_rvalid` in IDLE is ignored.
- Output register:
  - `redirect` → `if_valid <= 0` (priority over stall and capture).
  - Else capture → `if_valid <= 1`.
  - Else `if_valid & !stall` (consumed) → `if_valid <= 0`.
  - Else hold.
  - `if_instr`/`if_pcp1` change only on capture.
- The issue gating guarantees the output register is empty whenever a capture occurs.
- Arithmetic is 30-bit and wraps mod 2^30: 30'h3FFFFFFF + 1 = 0.

## Timing

- Reset values: `st`=IDLE, `fa`=`RESET_PC`, `pend`=0, `pend_tgt`=0, `iss_pcp1`=0, `if_valid`=0, `if_instr`=0, `if_pcp1`=0. `imem_req`=0 while `reset`=1.
- First request: the cycle after `reset` deasserts, with `imem_addr`=`RESET_PC`.
- Latency: accept at cycle t, `imem_rvalid` at t+k (k≥1) → `if_valid`=1 at t+k+1. The next request can issue at t+k+1.
- Zero-wait memory sustains 1 instruction per 2 cycles.
- `redirect` at cycle t: `imem_addr`=`JPC` in the same cycle. `if_valid`=0 at t+1. A stale response is never captured.
- Reset mid-transaction: outstanding state is dropped. The memory must not return data for a request accepted before reset; any such `imem_rvalid` is ignored in IDLE.
- `imem_addr` is only meaningful when `imem_req`=1. Memory samples it on accept only, so a redirect may change it while `imem_ready`=0.

## Test plan

- Reset, then `imem_ready`=1 and `imem_rvalid` 1 cycle after each accept → addresses 0xC00, 0xC01, 0xC02. Captured `if_pcp1` = 0xC01, 0xC02, 0xC03, each with matching `if_instr`.
- `if_valid`=1 with `stall` held 5 cycles → `imem_req`=0 and outputs stable. Drop `stall` → request for the next sequential address in the same cycle; `if_valid`=0 next cycle.
- In WAIT, `redirect` with `JPC`=0x1060, data returning 2 cycles later → data discarded, `if_valid`=0. Next accepted address is 0x1060; captured `if_pcp1`=0x1061.
- `redirect` coinciding with `imem_rvalid` in WAIT (`JPC`=0x0800) → nothing captured, `pend`=1. Next request address is 0x0800.
- IDLE with `imem_ready`=0, `redirect`/`JPC`=0x2000, then a second `redirect`/`JPC`=0x2400 → `imem_addr` shows 0x2400. On eventual accept the address is 0x2400 and `fa` becomes 0x2401.
- Redirect to 0x3FFFFFFF → `if_pcp1`=0 and the following sequential request address is 0. `reset` asserted in WAIT → all outputs at reset values next cycle, then restart at 0xC00.
